// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-op, state and control-word definitions for the hardwired control unit.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  // T0..T7 are consecutive codes so a step advances by incrementing the state.
  typedef enum logic [3:0] {
    RESET = 4'b0000,
    T0    = 4'b0111,
    T1    = 4'b1000,
    T2    = 4'b1001,
    T3    = 4'b1010,
    T4    = 4'b1011,
    T5    = 4'b1100,
    T6    = 4'b1101,
    T7    = 4'b1110,
    HALT  = 4'b1111
  } state_t;

  typedef struct packed {
    logic ld, ldi, st, alu, imm, br, jr, in_op, out_op, nop, halt;
  } instr_class_t;

  typedef struct packed {
    logic       pc_out, mdr_out, zlow_out, zhigh_out, hi_out, lo_out;
    logic       c_out, in_port_out, ba_out, r_out;
    logic       pc_enable, inc_pc, mar_enable, mdr_enable, ir_enable, y_enable;
    logic       z_enable, r_in, con_in, out_port_enable, in_port_enable;
    logic       read, ram_write_enable, gra, grb, grc;
    logic [4:0] opcode;
  } ctrl_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode decode into a one-hot instruction class plus the ALU op to issue.
// In/out are only recognised when CONTROL_IO_EN is defined; otherwise they fall to nop.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   op,
  output instr_class_t cls,
  output logic [4:0]   alu_op
);

  always_comb begin
    cls    = '0;
    alu_op = ALU_NONE;
    case (op)
      OP_LD:   begin cls.ld  = 1'b1; alu_op = ALU_ADD; end
      OP_LDI:  begin cls.ldi = 1'b1; alu_op = ALU_ADD; end
      OP_ST:   begin cls.st  = 1'b1; alu_op = ALU_ADD; end
      OP_ADD, OP_SUB, OP_AND, OP_OR:
               begin cls.alu = 1'b1; alu_op = op; end
      OP_ADDI: begin cls.imm = 1'b1; alu_op = ALU_ADD; end
      OP_ANDI: begin cls.imm = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin cls.imm = 1'b1; alu_op = ALU_OR; end
      OP_BR:   begin cls.br  = 1'b1; alu_op = ALU_ADD; end
      OP_JR:   cls.jr   = 1'b1;
`ifdef CONTROL_IO_EN
      OP_IN:   cls.in_op  = 1'b1;
      OP_OUT:  cls.out_op = 1'b1;
`endif
      OP_HALT: cls.halt = 1'b1;
      default: cls.nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: steps RESET -> T0..T7 -> T0/HALT and decodes one control word per step.
// Define CONTROL_IO_EN to enable the in/out instructions and their port strobes.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic [4:0]  opcode,
  output logic        PC_out,
  output logic        MDR_out,
  output logic        ZLow_out,
  output logic        ZHigh_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        C_out,
  output logic        in_port_out,
  output logic        BA_out,
  output logic        R_out,
  output logic        PC_enable,
  output logic        IncPC,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        R_in,
  output logic        con_in,
  output logic        out_port_enable,
  output logic        in_port_enable,
  output logic        Read,
  output logic        RAM_write_enable,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc
);

  state_t       state;
  logic         armed;
  instr_class_t cls;
  logic [4:0]   alu_op;
  logic         last_step;
  ctrl_t        ctrl;
  logic         unused_ir;

  // Only the opcode field matters here; register fields are consumed by the datapath.
  assign unused_ir = ^IR[26:0];

  instr_class_decode u_decode (
    .op     (IR[31:27]),
    .cls    (cls),
    .alu_op (alu_op)
  );

  always_comb begin
    last_step = 1'b0;
    case (state)
      T3:      last_step = cls.jr | cls.in_op | cls.out_op | cls.nop | cls.halt;
      T5:      last_step = cls.ldi | cls.alu | cls.imm;
      T6:      last_step = cls.br;
      T7:      last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  // armed holds RESET for one full cycle after clr falls before fetching.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RESET;
      armed <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          armed <= 1'b1;
          if (armed) state <= T0;
        end
        HALT:    state <= HALT;
        default: begin
          if (last_step) state <= (cls.halt || stop) ? HALT : T0;
          else           state <= state_t'(state + 4'd1);
        end
      endcase
    end
  end

  assign run = (state >= T0) && (state <= T7);

  always_comb begin
    ctrl = '0;
    case (state)
      T0: begin ctrl.pc_out = 1'b1; ctrl.mar_enable = 1'b1; ctrl.inc_pc = 1'b1; ctrl.pc_enable = 1'b1; end
      T1: begin ctrl.read = 1'b1; ctrl.mdr_enable = 1'b1; end
      T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_enable = 1'b1; end
      T3: begin
        if (cls.ld | cls.ldi | cls.st) begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_enable = 1'b1; end
        if (cls.alu | cls.imm)         begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_enable = 1'b1; end
        if (cls.br)     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
        if (cls.jr)     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_enable = 1'b1; end
        if (cls.in_op)  begin ctrl.in_port_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
        if (cls.out_op) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.out_port_enable = 1'b1; end
      end
      T4: begin
        if (cls.ld | cls.ldi | cls.st | cls.imm) begin ctrl.c_out = 1'b1; ctrl.z_enable = 1'b1; ctrl.opcode = alu_op; end
        if (cls.alu) begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_enable = 1'b1; ctrl.opcode = alu_op; end
        if (cls.br)  begin ctrl.pc_out = 1'b1; ctrl.y_enable = 1'b1; end
      end
      T5: begin
        if (cls.ld | cls.st)             begin ctrl.zlow_out = 1'b1; ctrl.mar_enable = 1'b1; end
        if (cls.ldi | cls.alu | cls.imm) begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
        if (cls.br) begin ctrl.c_out = 1'b1; ctrl.z_enable = 1'b1; ctrl.opcode = alu_op; end
      end
      T6: begin
        if (cls.ld) begin ctrl.read = 1'b1; ctrl.mdr_enable = 1'b1; end
        if (cls.st) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_enable = 1'b1; end
        if (cls.br && con_ff) begin ctrl.zlow_out = 1'b1; ctrl.pc_enable = 1'b1; end
      end
      T7: begin
        if (cls.ld) begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
        if (cls.st) ctrl.ram_write_enable = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign opcode           = ctrl.opcode;
  assign PC_out           = ctrl.pc_out;
  assign MDR_out          = ctrl.mdr_out;
  assign ZLow_out         = ctrl.zlow_out;
  assign ZHigh_out        = ctrl.zhigh_out;
  assign HI_out           = ctrl.hi_out;
  assign LO_out           = ctrl.lo_out;
  assign C_out            = ctrl.c_out;
  assign BA_out           = ctrl.ba_out;
  assign R_out            = ctrl.r_out;
  assign PC_enable        = ctrl.pc_enable;
  assign IncPC            = ctrl.inc_pc;
  assign MAR_enable       = ctrl.mar_enable;
  assign MDR_enable       = ctrl.mdr_enable;
  assign IR_enable        = ctrl.ir_enable;
  assign Y_enable         = ctrl.y_enable;
  assign Z_enable         = ctrl.z_enable;
  assign R_in             = ctrl.r_in;
  assign con_in           = ctrl.con_in;
  assign Read             = ctrl.read;
  assign RAM_write_enable = ctrl.ram_write_enable;
  assign Gra              = ctrl.gra;
  assign Grb              = ctrl.grb;
  assign Grc              = ctrl.grc;

`ifdef CONTROL_IO_EN
  assign in_port_out     = ctrl.in_port_out;
  assign out_port_enable = ctrl.out_port_enable;
  assign in_port_enable  = ctrl.in_port_enable;
`else
  logic unused_io;
  assign unused_io       = ctrl.in_port_out | ctrl.out_port_enable | ctrl.in_port_enable;
  assign in_port_out     = 1'b0;
  assign out_port_enable = 1'b0;
  assign in_port_enable  = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected control words are queued per step and popped each cycle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;
  logic        run;
  logic [4:0]  opcode;
  logic PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, in_port_out, BA_out, R_out;
  logic PC_enable, IncPC, MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, R_in, con_in;
  logic out_port_enable, in_port_enable, Read, RAM_write_enable, Gra, Grb, Grc;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .con_ff(con_ff), .stop(stop), .run(run), .opcode(opcode),
    .PC_out(PC_out), .MDR_out(MDR_out), .ZLow_out(ZLow_out), .ZHigh_out(ZHigh_out),
    .HI_out(HI_out), .LO_out(LO_out), .C_out(C_out), .in_port_out(in_port_out),
    .BA_out(BA_out), .R_out(R_out), .PC_enable(PC_enable), .IncPC(IncPC),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
    .Y_enable(Y_enable), .Z_enable(Z_enable), .R_in(R_in), .con_in(con_in),
    .out_port_enable(out_port_enable), .in_port_enable(in_port_enable), .Read(Read),
    .RAM_write_enable(RAM_write_enable), .Gra(Gra), .Grb(Grb), .Grc(Grc)
  );

  logic [31:0] obs;
  assign obs = {run, opcode, PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out,
                in_port_out, BA_out, R_out, PC_enable, IncPC, MAR_enable, MDR_enable, IR_enable,
                Y_enable, Z_enable, R_in, con_in, out_port_enable, in_port_enable, Read,
                RAM_write_enable, Gra, Grb, Grc};

  localparam logic [31:0] S_GRC = 32'd1 << 0,  S_GRB = 32'd1 << 1,  S_GRA = 32'd1 << 2;
  localparam logic [31:0] S_RAMW = 32'd1 << 3, S_READ = 32'd1 << 4, S_INEN = 32'd1 << 5;
  localparam logic [31:0] S_OUTEN = 32'd1 << 6, S_CONIN = 32'd1 << 7, S_RIN = 32'd1 << 8;
  localparam logic [31:0] S_ZEN = 32'd1 << 9, S_YEN = 32'd1 << 10, S_IREN = 32'd1 << 11;
  localparam logic [31:0] S_MDREN = 32'd1 << 12, S_MAREN = 32'd1 << 13, S_INCPC = 32'd1 << 14;
  localparam logic [31:0] S_PCEN = 32'd1 << 15, S_ROUT = 32'd1 << 16, S_BA = 32'd1 << 17;
  localparam logic [31:0] S_INOUT = 32'd1 << 18, S_COUT = 32'd1 << 19, S_ZLOW = 32'd1 << 23;
  localparam logic [31:0] S_MDROUT = 32'd1 << 24, S_PCOUT = 32'd1 << 25, S_RUN = 32'd1 << 31;

  int          checks = 0;
  int          errors = 0;
  int          ramWrites = 0;
  logic [31:0] expQ[$];

  always #5 clk = ~clk;

  always @(posedge RAM_write_enable) ramWrites++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int instrLen(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd2) return 8;
    if (op == 5'd18) return 7;
    if (op == 5'd1 || (op >= 5'd3 && op <= 5'd6) || (op >= 5'd12 && op <= 5'd14)) return 6;
    return 4;
  endfunction

  // Expected control word for step k of an instruction with opcode op.
  function automatic logic [31:0] expWord(input logic [4:0] op, input int k, input logic con);
    logic [31:0] w;
    logic [4:0]  aluf;
    w = S_RUN;
    aluf = 5'd0;
    if (k == 0) w |= S_PCOUT | S_MAREN | S_INCPC | S_PCEN;
    else if (k == 1) w |= S_READ | S_MDREN;
    else if (k == 2) w |= S_MDROUT | S_IREN;
    else if (op <= 5'd2) begin
      if (k == 3) w |= S_GRB | S_BA | S_YEN;
      if (k == 4) begin w |= S_COUT | S_ZEN; aluf = 5'd3; end
      if (k == 5) w |= (op == 5'd1) ? (S_ZLOW | S_GRA | S_RIN) : (S_ZLOW | S_MAREN);
      if (k == 6) w |= (op == 5'd0) ? (S_READ | S_MDREN) : (S_GRA | S_ROUT | S_MDREN);
      if (k == 7) w |= (op == 5'd0) ? (S_MDROUT | S_GRA | S_RIN) : S_RAMW;
    end else if (op >= 5'd3 && op <= 5'd6) begin
      if (k == 3) w |= S_GRB | S_ROUT | S_YEN;
      if (k == 4) begin w |= S_GRC | S_ROUT | S_ZEN; aluf = op; end
      if (k == 5) w |= S_ZLOW | S_GRA | S_RIN;
    end else if (op >= 5'd12 && op <= 5'd14) begin
      if (k == 3) w |= S_GRB | S_ROUT | S_YEN;
      if (k == 4) begin
        w |= S_COUT | S_ZEN;
        aluf = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
      end
      if (k == 5) w |= S_ZLOW | S_GRA | S_RIN;
    end else if (op == 5'd18) begin
      if (k == 3) w |= S_GRA | S_ROUT | S_CONIN;
      if (k == 4) w |= S_PCOUT | S_YEN;
      if (k == 5) begin w |= S_COUT | S_ZEN; aluf = 5'd3; end
      if (k == 6 && con) w |= S_ZLOW | S_PCEN;
    end else if (op == 5'd19) begin
      if (k == 3) w |= S_GRA | S_ROUT | S_PCEN;
    end
`ifdef CONTROL_IO_EN
    else if (op == 5'd22) begin
      if (k == 3) w |= S_INOUT | S_GRA | S_RIN;
    end else if (op == 5'd23) begin
      if (k == 3) w |= S_GRA | S_ROUT | S_OUTEN;
    end
`endif
    return w | ({27'd0, aluf} << 26);
  endfunction

  // Runs one instruction; IR is loaded at the end of T2 as the datapath would, con_ff at the end of T3.
  task automatic applyStimulus(input string name, input logic [31:0] ir, input logic con,
                               input logic stopEnd, input logic midPulse, input int abortAt);
    int          len;
    int          ramBefore;
    logic [31:0] e;
    len = instrLen(ir[31:27]);
    for (int k = 0; k < len; k++) expQ.push_back(expWord(ir[31:27], k, con));
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      e = expQ.pop_front();
      checkOutput($sformatf("%s_T%0d", name, k), obs, e);
      if (k == abortAt) begin
        clr = 1'b1;
        #1;
        checkOutput($sformatf("%s_clr_async", name), obs, 32'h0);
        expQ.delete();
        ramBefore = ramWrites;
        repeat (2) begin
          @(negedge clk);
          checkOutput($sformatf("%s_clr_hold", name), obs, 32'h0);
        end
        clr = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("%s_reset_hold", name), obs, 32'h0);
        checkOutput($sformatf("%s_no_ram_write", name), 32'(ramWrites - ramBefore), 32'h0);
        return;
      end
      stop = (k == len - 1) ? stopEnd : ((k == 1) ? midPulse : 1'b0);
      if (k == 2) IR = ir;
      if (k == 3) con_ff = con;
    end
  endtask

  task automatic checkHalted(input string name, input int n);
    for (int i = 0; i < n; i++) expQ.push_back(32'h0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_halt%0d", name, i), obs, expQ.pop_front());
    end
  endtask

  task automatic doReset(input string name);
    stop   = 1'b0;
    con_ff = 1'b0;
    clr    = 1'b1;
    #1;
    checkOutput($sformatf("%s_async", name), obs, 32'h0);
    @(negedge clk);
    checkOutput($sformatf("%s_held", name), obs, 32'h0);
    clr = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("%s_reset_cycle", name), obs, 32'h0);
  endtask

  initial begin
    #2;
    doReset("rst0");
    applyStimulus("ldi",   32'h0908_002D, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("ld",    32'h0090_002D, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("st",    32'h1000_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("add",   32'h1800_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("sub",   32'h2000_0000, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus("addi",  32'h6000_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("andi",  32'h6800_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("ori",   32'h7000_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("br1",   32'h9000_0000, 1'b1, 1'b0, 1'b0, -1);
    applyStimulus("br0",   32'h9000_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("in",    32'hB000_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("out",   32'hB800_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("bad",   32'hF800_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("nop",   32'hD000_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("jr",    32'h9800_0000, 1'b0, 1'b1, 1'b0, -1);
    checkHalted("stop", 3);
    doReset("rst1");
    applyStimulus("halt",  32'hD800_0000, 1'b0, 1'b0, 1'b0, -1);
    checkHalted("halt", 20);
    doReset("rst2");
    applyStimulus("st_ab", 32'h1000_0000, 1'b0, 1'b0, 1'b0, 5);
    applyStimulus("add2",  32'h1800_0000, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus("hstop", 32'hD800_0000, 1'b0, 1'b1, 1'b0, -1);
    checkHalted("hstop", 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control unit that sequences the processor datapath through instruction fetch and execute. Each clock cycle it drives exactly one control step (T0, T1, …) onto the datapath's control inputs, replacing the hand-written per-state stimulus used in datapath testbenches. It decodes the instruction register and branch condition and runs until a `halt` instruction or external `stop`.

## Interface
- No parameters. Opcode, ALU-op and state encodings are package constants.
- `clk`  in  1  system clock; all state changes on rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `IR`  in  32  instruction register from datapath. Opcode is `IR[31:27]`.
- `con_ff`  in  1  branch-condition flip-flop output from datapath.
- `stop`  in  1  external halt request.
- `run`  out  1  high while executing. Low in reset and HALT.
- `opcode`  out  5  ALU operation select.
- Bus-drive outputs, 1 bit each: `PC_out`, `MDR_out`, `ZLow_out`, `ZHigh_out`, `HI_out`, `LO_out`, `C_out`, `in_port_out`, `BA_out`, `R_out`.
- Register-enable outputs, 1 bit each: `PC_enable`, `IncPC`, `MAR_enable`, `MDR_enable`, `IR_enable`, `Y_enable`, `Z_enable`, `R_in`, `con_in`, `out_port_enable`, `in_port_enable`.
- Other 1-bit outputs: `Read`, `RAM_write_enable`, `Gra`, `Grb`, `Grc`.

## Operation
- State register values: RESET, T0–T7, HALT. Outputs are a combinational function of the state and `IR[31:27]`. Any output not listed for a step is 0.
- Fetch steps, common to all instructions:
  - T0: `PC_out`, `MAR_enable`, `IncPC`, `PC_enable`.
  - T1: `Read`, `MDR_enable`.
  - T2: `MDR_out`, `IR_enable`.
- Execute steps, T3 onward, per opcode:
  - ld 00000: T3 `Grb BA_out Y_enable`; T4 `C_out Z_enable opcode=00011`; T5 `ZLow_out MAR_enable`; T6 `Read MDR_enable`; T7 `MDR_out Gra R_in`.
  - ldi 00001: T3 and T4 as ld; T5 `ZLow_out Gra R_in`.
  - st 00010: T3–T5 as ld; T6 `Gra R_out MDR_enable` (Read=0); T7 `RAM_write_enable`.
  - add/sub/and/or 00011–00110: T3 `Grb R_out Y_enable`; T4 `Grc R_out Z_enable opcode=IR[31:27]`; T5 `ZLow_out Gra R_in`.
  - addi/andi/ori 01100/01101/01110: T3 `Grb R_out Y_enable`; T4 `C_out Z_enable` with opcode mapped to 00011/00101/00110; T5 `ZLow_out Gra R_in`.
  - br 10010: T3 `Gra R_out con_in`; T4 `PC_out Y_enable`; T5 `C_out Z_enable opcode=00011`; T6 `ZLow_out PC_enable` only if `con_ff`=1, otherwise no outputs asserted.
  - jr 10011: T3 `Gra R_out PC_enable`.
  - in 10110: T3 `in_port_out Gra R_in`.
  - out 10111: T3 `Gra R_out out_port_enable`.
  - nop 11010: T3 with no outputs asserted.
  - halt 11011: T3 with no outputs asserted, then HALT.
  - Any other opcode executes as nop.
- Transitions:
  - RESET → T0.
  - Each step advances to the next step.
  - After an instruction's last step, go to T0, or to HALT if `stop`=1 on that edge.
  - HALT is left only by `clr`.

## Timing
- Cycles per instruction, T0 through last step:
  - ld, st: 8.
  - br: 7.
  - ldi, ALU, immediate: 6.
  - jr, in, out, nop: 4.
- First T0 is the second rising edge after `clr` falls. The state is RESET for one cycle.
- `clr` high at any time:
  - state goes to RESET immediately, without waiting for a clock edge;
  - all outputs and `run` go to 0 in the same delta;
  - the interrupted instruction is abandoned with no further writes.
- `stop` is sampled only on the last-step edge. A pulse arriving mid-instruction is ignored unless it is still high at that edge.
- `halt` together with `stop`=1 gives a single HALT entry; there is no difference in behaviour.
- `con_ff` is sampled during T6 of br only. The datapath latches it at the end of T3.

## Configuration
- `CONTROL_IO_EN` defined: in/out decode as above.
- `CONTROL_IO_EN` undefined:
  - opcodes 10110/10111 execute as nop;
  - `in_port_out`, `in_port_enable` and `out_port_enable` are tied to 0.

## Structure
- Package `cpu_pkg` holds:
  - 5-bit opcode constants (`OP_LD` … `OP_HALT`);
  - ALU opcode values;
  - the 4-bit state enum (RESET=0000, T0=0111 … T7=1110, HALT=1111, matching testbench encodings).
- Sub-module `instr_class_decode` maps `IR[31:27]` to a one-hot instruction class and a mapped ALU opcode. It is purely combinational and reused by the disassembler testbench.

## Test plan
- Reset, then `ldi R2,$45(R1)` with IR=0x0908_002D: the T3–T5 sequence matches the spec and the cycle count is 6.
- `ld R1,$45(R2)` with IR=0x0090_002D: `Read`=1 in T1 and T6, `Gra`·`R_in` only in T7, next T0 on the 9th edge.
- `br` with IR[31:27]=10010:
  - `con_ff`=1: `ZLow_out`=`PC_enable`=1 in T6;
  - `con_ff`=0: all outputs 0 in T6.
- `halt` (11011): `run` falls after T3, the state stays HALT for 20 cycles, and `clr` pulse resumes at T0.
- `clr` asserted mid-T5 of st: all outputs 0 without a clock edge, and `RAM_write_enable` is never asserted.
- Opcode 11111 runs as nop in 4 cycles. With `CONTROL_IO_EN` undefined, `out` (10111) never asserts `out_port_enable`.
